// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_if
// Description : Bundle between the multicycle controller and its datapath /
//               memory. The master side is the controller: it consumes the
//               instruction opcode and the memory ready flag, and drives every
//               datapath control, the memory request strobes and status flags.
//   opcode[5:0]     instruction[31:26], stable from DECODE onward
//   mem_ready       memory finishes the current access this cycle
//   mem_req         memory access request
//   mem_write       memory write strobe (only ever with mem_req)
//   iord            address select: 0 = PC, 1 = ALU-out
//   ir_write        load instruction register
//   pc_write        load program counter
//   branch          conditional PC load on ALU zero
//   reg_write       register file write enable
//   reg_dst         destination select: 1 = rd, 0 = rt
//   mem_to_reg      write-back select: 1 = memory data, 0 = ALU-out
//   alu_src_a       ALU A select: 1 = regA, 0 = PC
//   alu_src_b[1:0]  ALU B select: 00 regB, 01 const 4, 10 sext imm, 11 imm<<2
//   alu_op[1:0]     00 add, 01 sub, 10 use funct field
//   pc_src[1:0]     00 ALU result, 01 ALU-out, 10 jump target
//   state[3:0]      current state code
//   illegal_op      one-cycle pulse on an unrecognised opcode in DECODE
//   instr_retired   one-cycle pulse per completed instruction
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic [3:0] state;
    logic       illegal_op;
    logic       instr_retired;

    modport master (
        input  opcode, mem_ready,
        output mem_req, mem_write, iord, ir_write, pc_write, branch,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_op, pc_src, state, illegal_op, instr_retired
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, mem_write, iord, ir_write, pc_write, branch,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_op, pc_src, state, illegal_op, instr_retired
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Moore-style control FSM for a multicycle MIPS-subset CPU
//               (lw, sw, R-type, beq, addi, j). Outputs are decoded from the
//               current state and mem_ready; illegal_op additionally looks at
//               the opcode while in DECODE. While reset is high every output
//               except state is held low.
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high; loads FETCH
//   bus    : multicycle_controller_if.master (see interface for signals)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller (
    input  logic                           clk,
    input  logic                           reset,
    multicycle_controller_if.master        bus
);

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXECUTE = 4'd6,
        ST_ALUWB   = 4'd7,
        ST_BEQ     = 4'd8,
        ST_ADDIEX  = 4'd9,
        ST_ADDIWB  = 4'd10,
        ST_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    state_t state_d;

    logic       w_op_known;
    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_iord;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_src;
    logic       w_illegal_op;
    logic       w_instr_retired;

    always_comb begin
        w_op_known = 1'b0;
        case (bus.opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: w_op_known = 1'b1;
            default:                                      w_op_known = 1'b0;
        endcase
    end

    // Next-state logic. Codes 12-15 are unreachable in normal operation and
    // fall through to FETCH via the default arm.
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:   state_d = bus.mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXECUTE;
                    OP_BEQ:       state_d = ST_BEQ;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR:  state_d = (bus.opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:   state_d = bus.mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:   state_d = ST_FETCH;
            ST_MEMWR:   state_d = bus.mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXECUTE: state_d = ST_ALUWB;
            ST_ALUWB:   state_d = ST_FETCH;
            ST_BEQ:     state_d = ST_FETCH;
            ST_ADDIEX:  state_d = ST_ADDIWB;
            ST_ADDIWB:  state_d = ST_FETCH;
            ST_JUMP:    state_d = ST_FETCH;
            default:    state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode. The memory-wait states (FETCH, MEMWR) qualify their
    // one-shot effects with mem_ready so that each effect happens once, on
    // the cycle the access actually completes.
    always_comb begin
        w_mem_req       = 1'b0;
        w_mem_write     = 1'b0;
        w_iord          = 1'b0;
        w_ir_write      = 1'b0;
        w_pc_write      = 1'b0;
        w_branch        = 1'b0;
        w_reg_write     = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_pc_src        = 2'b00;
        w_illegal_op    = 1'b0;
        w_instr_retired = 1'b0;
        case (state_q)
            ST_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
            end
            ST_DECODE: begin
                w_alu_src_b  = 2'b11;
                w_illegal_op = ~w_op_known;
            end
            ST_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            ST_MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
            end
            ST_MEMWB: begin
                w_reg_write     = 1'b1;
                w_mem_to_reg    = 1'b1;
                w_instr_retired = 1'b1;
            end
            ST_MEMWR: begin
                w_mem_req       = 1'b1;
                w_mem_write     = 1'b1;
                w_iord          = 1'b1;
                w_instr_retired = bus.mem_ready;
            end
            ST_EXECUTE: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
            end
            ST_ALUWB: begin
                w_reg_write     = 1'b1;
                w_reg_dst       = 1'b1;
                w_instr_retired = 1'b1;
            end
            ST_BEQ: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_branch        = 1'b1;
                w_pc_src        = 2'b01;
                w_instr_retired = 1'b1;
            end
            ST_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            ST_ADDIWB: begin
                w_reg_write     = 1'b1;
                w_instr_retired = 1'b1;
            end
            ST_JUMP: begin
                w_pc_write      = 1'b1;
                w_pc_src        = 2'b10;
                w_instr_retired = 1'b1;
            end
            default: begin
            end
        endcase

        // Reset overrides everything so an abandoned access cannot strobe
        // memory or the register file while the FSM is being reloaded.
        if (reset) begin
            w_mem_req       = 1'b0;
            w_mem_write     = 1'b0;
            w_iord          = 1'b0;
            w_ir_write      = 1'b0;
            w_pc_write      = 1'b0;
            w_branch        = 1'b0;
            w_reg_write     = 1'b0;
            w_reg_dst       = 1'b0;
            w_mem_to_reg    = 1'b0;
            w_alu_src_a     = 1'b0;
            w_alu_src_b     = 2'b00;
            w_alu_op        = 2'b00;
            w_pc_src        = 2'b00;
            w_illegal_op    = 1'b0;
            w_instr_retired = 1'b0;
        end
    end

    assign bus.mem_req       = w_mem_req;
    assign bus.mem_write     = w_mem_write;
    assign bus.iord          = w_iord;
    assign bus.ir_write      = w_ir_write;
    assign bus.pc_write      = w_pc_write;
    assign bus.branch        = w_branch;
    assign bus.reg_write     = w_reg_write;
    assign bus.reg_dst       = w_reg_dst;
    assign bus.mem_to_reg    = w_mem_to_reg;
    assign bus.alu_src_a     = w_alu_src_a;
    assign bus.alu_src_b     = w_alu_src_b;
    assign bus.alu_op        = w_alu_op;
    assign bus.pc_src        = w_pc_src;
    assign bus.state         = state_q;
    assign bus.illegal_op    = w_illegal_op;
    assign bus.instr_retired = w_instr_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed testbench for multicycle_controller. A reference
//               model describes each instruction as an ordered list of steps
//               (state codes), some of which stall on mem_ready; expected
//               outputs are derived from the current step of that list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ILL  = 6'b111111;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    multicycle_controller_if bus_if ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks       = 0;
    int failures     = 0;
    int m_idx        = 0;
    bit m_valid      = 1'b0;
    bit done         = 1'b0;
    int retired_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Number of steps an instruction takes (illegal: FETCH + DECODE only).
    function automatic int seq_len(input logic [5:0] op);
        case (op)
            OP_LW:   return 5;
            OP_SW:   return 4;
            OP_RT:   return 4;
            OP_BEQ:  return 3;
            OP_ADDI: return 4;
            OP_J:    return 3;
            default: return 2;
        endcase
    endfunction

    // State code visited at position idx of an instruction's step list.
    function automatic int seq_step(input logic [5:0] op, input int idx);
        if (idx == 0) return 0;
        if (idx == 1) return 1;
        case (op)
            OP_LW:   return (idx == 2) ? 2 : (idx == 3) ? 3 : 4;
            OP_SW:   return (idx == 2) ? 2 : 5;
            OP_RT:   return (idx == 2) ? 6 : 7;
            OP_BEQ:  return 8;
            OP_ADDI: return (idx == 2) ? 9 : 10;
            OP_J:    return 11;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_wait(input int st);
        return (st == 0) || (st == 3) || (st == 5);
    endfunction

    function automatic logic [17:0] model_outs(input int idx, input logic [5:0] op, input logic mr);
        int st;
        int len;
        bit legal;
        logic mreq, mw, io, irw, pcw, br, rw, rd, m2r, asa, ill, ret;
        logic [1:0] asb, aop, pcs;
        st    = seq_step(op, idx);
        len   = seq_len(op);
        legal = (len > 2);
        mreq  = (st == 0) || (st == 3) || (st == 5);
        mw    = (st == 5);
        io    = (st == 3) || (st == 5);
        irw   = (st == 0) && mr;
        pcw   = ((st == 0) && mr) || (st == 11);
        br    = (st == 8);
        rw    = (st == 4) || (st == 7) || (st == 10);
        rd    = (st == 7);
        m2r   = (st == 4);
        asa   = (st == 2) || (st == 6) || (st == 8) || (st == 9);
        asb   = (st == 0) ? 2'b01 : (st == 1) ? 2'b11 : ((st == 2) || (st == 9)) ? 2'b10 : 2'b00;
        aop   = (st == 6) ? 2'b10 : (st == 8) ? 2'b01 : 2'b00;
        pcs   = (st == 8) ? 2'b01 : (st == 11) ? 2'b10 : 2'b00;
        ill   = (st == 1) && !legal;
        // An instruction retires as it leaves its final step.
        ret   = legal && (idx == len - 1) && !(is_wait(st) && !mr);
        return {mreq, mw, io, irw, pcw, br, rw, rd, m2r, asa, asb, aop, pcs, ill, ret};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_idx   <= 0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            if (!(is_wait(seq_step(bus_if.opcode, m_idx)) && !bus_if.mem_ready)) begin
                if (m_idx + 1 >= seq_len(bus_if.opcode)) m_idx <= 0;
                else                                     m_idx <= m_idx + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus_if.instr_retired) retired_seen <= retired_seen + 1;
    end

    always @(negedge clk) begin
        logic [17:0] act_o;
        logic [17:0] exp_o;
        if (!done && (m_valid || reset)) begin
            act_o = {bus_if.mem_req, bus_if.mem_write, bus_if.iord, bus_if.ir_write,
                     bus_if.pc_write, bus_if.branch, bus_if.reg_write, bus_if.reg_dst,
                     bus_if.mem_to_reg, bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op,
                     bus_if.pc_src, bus_if.illegal_op, bus_if.instr_retired};
            exp_o = reset ? 18'd0 : model_outs(m_idx, bus_if.opcode, bus_if.mem_ready);
            chk("outputs", 32'(act_o), 32'(exp_o));
            if (m_valid) chk("state_model", 32'(bus_if.state), 32'(seq_step(bus_if.opcode, m_idx)));
        end
    end

    task automatic step(input logic r, input logic [5:0] op, input logic mr, input int exp_state);
        @(posedge clk);
        #1;
        reset            = r;
        bus_if.opcode    = op;
        bus_if.mem_ready = mr;
        @(negedge clk);
        #1;
        if (exp_state >= 0) chk("state_literal", 32'(bus_if.state), 32'(exp_state));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        reset            = 1'b1;
        bus_if.opcode    = OP_RT;
        bus_if.mem_ready = 1'b1;

        // Model sanity: hand-computed latencies with mem_ready tied high.
        chk("lat_rtype", 32'(seq_len(OP_RT)), 32'd4);
        chk("lat_lw", 32'(seq_len(OP_LW)), 32'd5);
        chk("lat_ill", 32'(seq_len(OP_ILL)), 32'd2);

        step(1, OP_RT, 1, -1);
        step(1, OP_RT, 1, 0);

        // R-type
        base = retired_seen;
        step(0, OP_RT, 1, 0);
        step(0, OP_RT, 1, 1);
        step(0, OP_RT, 1, 6);
        chk("rt_reg_write_exec", 32'(bus_if.reg_write), 32'd0);
        step(0, OP_RT, 1, 7);
        chk("rt_reg_write", 32'(bus_if.reg_write), 32'd1);
        chk("rt_reg_dst", 32'(bus_if.reg_dst), 32'd1);
        step(0, OP_LW, 0, 0);
        chk("rt_retired", 32'(retired_seen - base), 32'd1);

        // lw with two fetch wait cycles (first FETCH cycle above)
        base = retired_seen;
        chk("lw_ir_write_wait", 32'(bus_if.ir_write), 32'd0);
        step(0, OP_LW, 0, 0);
        chk("lw_pc_write_wait", 32'(bus_if.pc_write), 32'd0);
        step(0, OP_LW, 1, 0);
        chk("lw_ir_write", 32'(bus_if.ir_write), 32'd1);
        chk("lw_pc_write", 32'(bus_if.pc_write), 32'd1);
        step(0, OP_LW, 1, 1);
        step(0, OP_LW, 1, 2);
        step(0, OP_LW, 1, 3);
        step(0, OP_LW, 1, 4);
        chk("lw_mem_to_reg", 32'(bus_if.mem_to_reg), 32'd1);

        // sw with one MEMWR wait
        step(0, OP_SW, 1, 0);
        chk("lw_retired", 32'(retired_seen - base), 32'd1);
        base = retired_seen;
        step(0, OP_SW, 1, 1);
        step(0, OP_SW, 1, 2);
        step(0, OP_SW, 0, 5);
        chk("sw_strobes_wait", 32'({bus_if.mem_write, bus_if.mem_req, bus_if.iord}), 32'd7);
        chk("sw_no_retire_wait", 32'(bus_if.instr_retired), 32'd0);
        step(0, OP_SW, 1, 5);
        chk("sw_strobes_done", 32'({bus_if.mem_write, bus_if.mem_req, bus_if.iord}), 32'd7);
        chk("sw_retire", 32'(bus_if.instr_retired), 32'd1);

        // beq then j
        step(0, OP_BEQ, 1, 0);
        step(0, OP_BEQ, 1, 1);
        step(0, OP_BEQ, 1, 8);
        chk("beq_branch", 32'(bus_if.branch), 32'd1);
        chk("beq_pc_src", 32'(bus_if.pc_src), 32'd1);
        step(0, OP_J, 1, 0);
        step(0, OP_J, 1, 1);
        step(0, OP_J, 1, 11);
        chk("j_pc_write", 32'(bus_if.pc_write), 32'd1);
        chk("j_pc_src", 32'(bus_if.pc_src), 32'd2);

        // illegal opcode
        step(0, OP_ILL, 1, 0);
        base = retired_seen;
        step(0, OP_ILL, 1, 1);
        chk("ill_pulse", 32'(bus_if.illegal_op), 32'd1);
        step(0, OP_ILL, 1, 0);
        chk("ill_pulse_end", 32'(bus_if.illegal_op), 32'd0);
        chk("ill_no_retire", 32'(retired_seen - base), 32'd0);

        // addi (first FETCH shares the cycle above, opcode now switched)
        step(0, OP_ADDI, 1, 1);
        step(0, OP_ADDI, 1, 9);
        step(0, OP_ADDI, 1, 10);
        chk("addi_reg_write", 32'(bus_if.reg_write), 32'd1);
        chk("addi_reg_dst", 32'(bus_if.reg_dst), 32'd0);

        // reset while a store waits for memory
        step(0, OP_SW, 1, 0);
        step(0, OP_SW, 1, 1);
        step(0, OP_SW, 1, 2);
        step(0, OP_SW, 0, 5);
        base = retired_seen;
        step(1, OP_SW, 0, 5);
        chk("rst_mem_write", 32'(bus_if.mem_write), 32'd0);
        chk("rst_mem_req", 32'(bus_if.mem_req), 32'd0);
        step(0, OP_SW, 0, 0);
        chk("rst_fetch_req", 32'(bus_if.mem_req), 32'd1);
        step(0, OP_RT, 1, 0);
        chk("rst_no_retire", 32'(retired_seen - base), 32'd0);
        step(0, OP_RT, 1, 1);
        step(0, OP_RT, 1, 6);

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
